watch_ctrl: RTL and testbench

User-interface controller for the six-digit HH:MM:SS counter. It conditions five push-buttons with synchronisation and debouncing, then runs a RUN/PAUSED/SET mode FSM. It drives the counter's enable, clr, config_digit and config_add inputs, and a per-digit blink mask for the display driver. It sits between the board buttons and the counter, with one instance per watch.

---
 rtl/watch_pkg.sv | 24 ++
 rtl/watch_ctrl_btn_conditioner.sv | 45 ++++
 rtl/watch_ctrl.sv | 151 +++++++++++++++
 tb/tb_watch_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared constants for the watch user-interface controller: mode encoding,
// digit indices and the blink one-hot helper.
package watch_pkg;

  localparam int unsigned NUM_DIGITS = 6;

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] PAUSED = 2'd1;
  localparam logic [1:0] SET    = 2'd2;

  localparam logic [2:0] DIG_SU = 3'd0;
  localparam logic [2:0] DIG_ST = 3'd1;
  localparam logic [2:0] DIG_MU = 3'd2;
  localparam logic [2:0] DIG_MT = 3'd3;
  localparam logic [2:0] DIG_HU = 3'd4;
  localparam logic [2:0] DIG_HD = 3'd5;

  function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [2:0] d);
    logic [NUM_DIGITS-1:0] one;
    one = NUM_DIGITS'(1);
    return one << d;
  endfunction

endpackage

// File: rtl/watch_ctrl_btn_conditioner.sv
// Button conditioner: 2-FF synchroniser, stability-count debouncer and a
// registered one-cycle press pulse on the rising edge of the debounced level.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      // Level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt   <= '0;
        level <= ~level;
      end else begin
        cnt <= cnt + CW'(1);
      end
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

endmodule

// File: rtl/watch_ctrl.sv
// RUN/PAUSED/SET mode controller for the HH:MM:SS counter: button
// conditioning, digit selection, increment with auto-repeat, and blink mask.
module watch_ctrl
  import watch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned HOLD_CYCLES     = 25_000_000,
  parameter int unsigned REPEAT_CYCLES   = 10_000_000,
  parameter int unsigned BLINK_HALF      = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_run,
  input  logic       btn_next,
  input  logic       btn_inc,
  input  logic       btn_clr,
  output logic       enable,
  output logic       clr,
  output logic [2:0] config_digit,
  output logic       config_add,
  output logic       set_mode,
  output logic [5:0] blink_mask
);

  localparam int unsigned RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HW      = $clog2(RPT_MAX + 1);
  localparam int unsigned BW      = $clog2(BLINK_HALF + 1);

  logic       p_mode, p_run, p_next, p_inc, p_clr;
  logic       inc_level;
  logic [3:0] unused_level;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
    .clk(clk), .rst(rst), .btn(btn_clr), .level(unused_level[0]), .press(p_clr));
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clk(clk), .rst(rst), .btn(btn_mode), .level(unused_level[1]), .press(p_mode));
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
    .clk(clk), .rst(rst), .btn(btn_run), .level(unused_level[2]), .press(p_run));
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk(clk), .rst(rst), .btn(btn_next), .level(unused_level[3]), .press(p_next));
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clk(clk), .rst(rst), .btn(btn_inc), .level(inc_level), .press(p_inc));

  logic [1:0]    state, state_n;
  logic [2:0]    digit_n;
  logic          clr_n, add_n;
  logic          hold_act, hold_act_n, hold_rep, hold_rep_n;
  logic [HW-1:0] hold_cnt, hold_cnt_n;
  logic [BW-1:0] blink_cnt, blink_cnt_n;
  logic          phase, phase_n, blink_clr;
  logic [5:0]    mask_n;
  logic          rep_fire, act_clr, act_mode, act_run, act_next, act_inc, act_rep;

  always_comb begin
    rep_fire = hold_act && inc_level &&
               (hold_cnt == (hold_rep ? HW'(REPEAT_CYCLES) : HW'(HOLD_CYCLES)));
    act_clr  = p_clr;
    act_mode = !p_clr && p_mode;
    act_run  = !p_clr && !p_mode && p_run;
    act_next = !p_clr && !p_mode && !p_run && p_next;
    act_inc  = !p_clr && !p_mode && !p_run && !p_next && p_inc;
    act_rep  = !(p_clr || p_mode || p_run || p_next || p_inc) && rep_fire;

    state_n    = state;
    digit_n    = config_digit;
    clr_n      = 1'b0;
    add_n      = 1'b0;
    blink_clr  = 1'b0;
    hold_act_n = hold_act;
    hold_rep_n = hold_rep;
    hold_cnt_n = hold_act ? hold_cnt + HW'(1) : '0;

    if (act_clr) begin
      clr_n = 1'b1;
      if (state == SET) digit_n = DIG_HD;
    end else if (act_mode) begin
      if (state == SET) begin
        state_n = RUN;
      end else begin
        state_n   = SET;
        digit_n   = DIG_HD;
        blink_clr = 1'b1;
      end
    end else if (act_run) begin
      if (state == RUN)         state_n = PAUSED;
      else if (state == PAUSED) state_n = RUN;
    end else if (state == SET) begin
      if (act_next) begin
        digit_n   = (config_digit == DIG_SU) ? DIG_HD : config_digit - 3'd1;
        blink_clr = 1'b1;
      end else if (act_inc || act_rep) begin
        add_n      = 1'b1;
        blink_clr  = 1'b1;
        hold_act_n = 1'b1;
        hold_rep_n = act_rep;
        hold_cnt_n = HW'(1);
      end
    end

    // Any higher-priority press, release or leaving SET stops auto-repeat.
    if (act_clr || act_mode || act_run || act_next || !inc_level || state_n != SET) begin
      hold_act_n = 1'b0;
      hold_rep_n = 1'b0;
      hold_cnt_n = '0;
    end

    phase_n     = phase;
    blink_cnt_n = blink_cnt + BW'(1);
    if (blink_clr) begin
      blink_cnt_n = '0;
      phase_n     = 1'b0;
    end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
      blink_cnt_n = '0;
      phase_n     = ~phase;
    end

    mask_n = (state_n == SET && phase_n) ? digit_onehot(digit_n) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      config_digit <= DIG_HD;
      enable       <= 1'b1;
      clr          <= 1'b0;
      config_add   <= 1'b0;
      set_mode     <= 1'b0;
      blink_mask   <= '0;
      hold_act     <= 1'b0;
      hold_rep     <= 1'b0;
      hold_cnt     <= '0;
      blink_cnt    <= '0;
      phase        <= 1'b0;
    end else begin
      state        <= state_n;
      config_digit <= digit_n;
      enable       <= (state_n == RUN);
      clr          <= clr_n;
      config_add   <= add_n;
      set_mode     <= (state_n == SET);
      blink_mask   <= mask_n;
      hold_act     <= hold_act_n;
      hold_rep     <= hold_rep_n;
      hold_cnt     <= hold_cnt_n;
      blink_cnt    <= blink_cnt_n;
      phase        <= phase_n;
    end
  end

endmodule

// File: tb/tb_watch_ctrl.sv
// Scoreboard bench for watch_ctrl: a window-based behavioural model predicts
// every change of the output vector and a monitor compares each DUT change.
module tb_watch_ctrl;

  localparam int D = 4;
  localparam int H = 20;
  localparam int R = 8;
  localparam int B = 16;
  localparam int MAXE = 20000;
  localparam logic [12:0] RESET_VEC = {1'b1, 1'b0, 3'd5, 1'b0, 1'b0, 6'b0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] btn = '0;   // 0 clr, 1 mode, 2 run, 3 next, 4 inc
  logic       enable, clr, config_add, set_mode;
  logic [2:0] config_digit;
  logic [5:0] blink_mask;
  logic [12:0] dut_vec;

  always #5 clk = ~clk;

  watch_ctrl #(
    .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .BLINK_HALF(B)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_mode(btn[1]), .btn_run(btn[2]), .btn_next(btn[3]), .btn_inc(btn[4]), .btn_clr(btn[0]),
    .enable(enable), .clr(clr), .config_digit(config_digit), .config_add(config_add),
    .set_mode(set_mode), .blink_mask(blink_mask)
  );

  assign dut_vec = {enable, clr, config_digit, config_add, set_mode, blink_mask};

  int checks = 0;
  int failures = 0;

  typedef struct { int at; logic [12:0] vec; } ev_t;
  ev_t exp_q[$];

  // ---------------- reference model ----------------
  typedef enum {M_RUN, M_PAUSED, M_SET} mmode_t;
  mmode_t      m_mode = M_RUN;
  int          m_digit = 5;
  bit          m_hold = 0;
  int          m_start = 0;
  int          m_blink_ref = 0;
  int          last_rst = -1;
  int          edge_n = 0;
  bit          lvl [5];
  bit          samp [5][MAXE];
  bit          rose [5][MAXE];
  logic [12:0] m_prev = RESET_VEC;

  task automatic model_step();
    int          n, win;
    bit          due [5];
    bit          fire, m_clr, m_add, all_diff, ph;
    logic [5:0]  mask;
    logic [12:0] v;
    n = edge_n;
    if (n >= MAXE) begin
      $display("FAIL model_capacity edge=%0d limit=%0d", n, MAXE);
      $fatal(1);
    end
    for (int b = 0; b < 5; b++) begin
      samp[b][n] = btn[b];
      rose[b][n] = 1'b0;
    end
    m_clr = 0;
    m_add = 0;
    if (rst) begin
      for (int b = 0; b < 5; b++) begin
        samp[b][n] = 1'b0;
        if (n > 0) samp[b][n-1] = 1'b0;
        lvl[b] = 1'b0;
      end
      last_rst = n; m_mode = M_RUN; m_digit = 5; m_hold = 0; m_blink_ref = n;
    end else begin
      for (int b = 0; b < 5; b++)
        due[b] = (n >= 2) && rose[b][n-2] && (n - 2 > last_rst);
      fire = m_hold && lvl[4] && (n - m_start >= H) && ((n - m_start - H) % R == 0);
      win = -1;
      for (int b = 0; b < 5; b++) if (due[b] && win < 0) win = b;
      if (win < 0 && fire) win = 5;
      case (win)
        0: begin m_clr = 1; if (m_mode == M_SET) m_digit = 5; end
        1: if (m_mode == M_SET) m_mode = M_RUN;
           else begin m_mode = M_SET; m_digit = 5; m_blink_ref = n; end
        2: if (m_mode == M_RUN) m_mode = M_PAUSED;
           else if (m_mode == M_PAUSED) m_mode = M_RUN;
        3: if (m_mode == M_SET) begin
             m_digit = (m_digit == 0) ? 5 : m_digit - 1;
             m_blink_ref = n;
           end
        4, 5: if (m_mode == M_SET) begin
             m_add = 1; m_blink_ref = n;
             if (win == 4) begin m_hold = 1; m_start = n; end
           end
        default: ;
      endcase
      if ((win >= 0 && win <= 3) || !lvl[4] || m_mode != M_SET) m_hold = 0;
      for (int b = 0; b < 5; b++) begin
        if (n >= D + 1) begin
          all_diff = 1;
          for (int k = 2; k <= D + 1; k++) if (samp[b][n-k] == lvl[b]) all_diff = 0;
          if (all_diff) begin
            lvl[b] = ~lvl[b];
            rose[b][n] = lvl[b];
          end
        end
      end
    end
    ph   = (((n - m_blink_ref) / B) % 2) == 1;
    mask = (m_mode == M_SET && ph) ? (6'b1 << m_digit) : 6'b0;
    v    = {m_mode == M_RUN, m_clr, 3'(m_digit), m_add, m_mode == M_SET, mask};
    if (v !== m_prev) exp_q.push_back('{at: n, vec: v});
    m_prev = v;
    edge_n++;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- monitor ----------------
  logic [12:0] prev_dut;
  bit          cnt_en = 0;
  int          add_count = 0, clr_count = 0, set_count = 0;

  initial begin
    ev_t e;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (dut_vec !== RESET_VEC) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b", dut_vec, RESET_VEC);
    end
    prev_dut = RESET_VEC;
    forever begin
      @(negedge clk);
      if (cnt_en) begin
        if (config_add) add_count++;
        if (clr) clr_count++;
        if (set_mode) set_count++;
      end
      if (dut_vec !== prev_dut) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change edge=%0d got=%b", edge_n - 1, dut_vec);
        end else begin
          e = exp_q.pop_front();
          if (e.vec !== dut_vec || e.at != edge_n - 1) begin
            failures++;
            $display("FAIL output_change got=%b@%0d exp=%b@%0d", dut_vec, edge_n - 1, e.vec, e.at);
          end
        end
        prev_dut = dut_vec;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hold_btn(input logic [4:0] m, input int n);
    btn = m;
    repeat (n) @(negedge clk);
    btn = '0;
  endtask

  task automatic tap(input logic [4:0] m);
    hold_btn(m, 6);
    idle(12);
  endtask

  task automatic start_count();
    add_count = 0; clr_count = 0; set_count = 0; cnt_en = 1;
  endtask

  initial begin
    logic [4:0] m;
    repeat (3) @(negedge clk);
    rst = 0;
    idle(10);
    check("idle_enable", int'(enable), 1);
    check("idle_digit", int'(config_digit), 5);

    hold_btn(5'b00100, 3);            // bounce: too short to register
    idle(10);
    check("bounce_ignored", int'(enable), 1);
    hold_btn(5'b00100, 10);           // run -> PAUSED
    idle(15);
    check("paused_enable", int'(enable), 0);

    tap(5'b00010);                    // SET
    tap(5'b01000);
    tap(5'b01000);
    check("digit_after_two_next", int'(config_digit), 3);
    start_count();
    tap(5'b10000);
    cnt_en = 0;
    check("single_inc_adds", add_count, 1);

    start_count();
    hold_btn(5'b10000, 60);           // auto-repeat
    idle(15);
    cnt_en = 0;
    check("hold_inc_adds", add_count, 6);

    repeat (3) tap(5'b01000);
    check("digit_zero", int'(config_digit), 0);
    tap(5'b01000);
    check("digit_wrap", int'(config_digit), 5);
    idle(40);
    tap(5'b10000);
    tap(5'b00010);                    // back to RUN

    start_count();
    tap(5'b00011);                    // clr + mode together
    cnt_en = 0;
    check("clr_mode_clr_pulses", clr_count, 1);
    check("clr_mode_no_set", set_count, 0);

    tap(5'b00010);                    // SET
    btn = 5'b10000;
    idle(25);
    rst = 1;
    idle(1);
    rst = 0;
    check("rst_in_set_vec", int'({enable, config_digit, set_mode}), int'({1'b1, 3'd5, 1'b0}));
    start_count();
    idle(30);
    btn = '0;
    idle(15);
    cnt_en = 0;
    check("no_add_after_rst", add_count, 0);

    for (int it = 0; it < 120; it++) begin
      if ($urandom_range(0, 3) == 0) m = 5'($urandom_range(1, 31));
      else m = 5'(1) << $urandom_range(0, 4);
      if ($urandom_range(0, 2) == 0) m[4] = 1'b1;
      hold_btn(m, $urandom_range(1, 40));
      idle($urandom_range(2, 20));
      if ($urandom_range(0, 29) == 0) begin
        rst = 1;
        idle($urandom_range(1, 2));
        rst = 0;
      end
    end

    idle(60);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
